// File: rtl/cook_sequencer.sv
// Cook-cycle controller: sequences keypad load/clear, cook/pause/done phases,
// derives the timer decrement tick and drives magnetron enable and end beep.
module cook_sequencer #(
  parameter int TICK_DIV    = 50000000,
  parameter int DONE_CYCLES = 100000000
) (
  input  logic       clock,
  input  logic       clrn,
  input  logic       key_valid,
  input  logic       start,
  input  logic       stop_clear,
  input  logic       door_closed,
  input  logic       timer_zero,
  output logic       timer_loadn,
  output logic       timer_clrn,
  output logic       timer_enable,
  output logic       mag_on,
  output logic       done_beep,
  output logic [2:0] state
);

  // state | meaning
  // IDLE  | waiting for first keypad digit
  // SET   | digits being entered, waiting for start
  // COOK  | magnetron on, timer counting down
  // PAUSE | cook suspended, prescaler held
  // DONE  | end-of-cook beep
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SET   = 3'd1,
    COOK  = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BW = (DONE_CYCLES > 1) ? $clog2(DONE_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BEEP_LOAD = BW'(DONE_CYCLES - 1);

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [BW-1:0]   beep_q, beep_d;
  logic            loadn_d, clrn_d, en_d, mag_d, beep_on_d;

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    beep_d    = beep_q;
    loadn_d   = 1'b1;
    clrn_d    = 1'b1;
    en_d      = 1'b0;
    beep_on_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_valid) begin
          loadn_d = 1'b0;
          state_d = SET;
        end
      end
      SET: begin
        if (stop_clear) begin
          clrn_d  = 1'b0;
          state_d = IDLE;
        end else if (start && door_closed && !timer_zero) begin
          state_d = COOK;
          presc_d = '0;
        end else if (key_valid) begin
          loadn_d = 1'b0;
        end
      end
      COOK: begin
        // timer_zero is stale while a decrement is in flight, so it is ignored then
        if (stop_clear || !door_closed) begin
          state_d = PAUSE;
        end else if (timer_zero && !timer_enable) begin
          state_d   = DONE;
          beep_d    = BEEP_LOAD;
          beep_on_d = 1'b1;
        end else if (presc_q == PRESC_MAX) begin
          presc_d = '0;
          en_d    = 1'b1;
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      PAUSE: begin
        if (stop_clear) begin
          clrn_d  = 1'b0;
          presc_d = '0;
          state_d = IDLE;
        end else if (start && door_closed) begin
          state_d = COOK;
        end
      end
      DONE: begin
        if (stop_clear || beep_q == '0) begin
          state_d = IDLE;
        end else begin
          beep_d    = beep_q - BW'(1);
          beep_on_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    mag_d = (state_d == COOK);
  end

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      state_q      <= IDLE;
      presc_q      <= '0;
      beep_q       <= '0;
      timer_loadn  <= 1'b1;
      timer_clrn   <= 1'b1;
      timer_enable <= 1'b0;
      mag_on       <= 1'b0;
      done_beep    <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      beep_q       <= beep_d;
      timer_loadn  <= loadn_d;
      timer_clrn   <= clrn_d;
      timer_enable <= en_d;
      mag_on       <= mag_d;
      done_beep    <= beep_on_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_cook_sequencer.sv
// Scoreboard bench for cook_sequencer: stimulus queues per-cycle expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_cook_sequencer;

  logic       clock = 1'b0;
  logic       clrn = 1'b0;
  logic       key_valid = 1'b0, start = 1'b0, stop_clear = 1'b0;
  logic       door_closed = 1'b1, timer_zero = 1'b0;
  logic       timer_loadn, timer_clrn, timer_enable, mag_on, done_beep;
  logic [2:0] state;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int         cyc;
    logic [7:0] v;
    string      nm;
  } exp_t;
  exp_t sb[$];

  cook_sequencer #(.TICK_DIV(4), .DONE_CYCLES(3)) dut (
    .clock(clock), .clrn(clrn), .key_valid(key_valid), .start(start),
    .stop_clear(stop_clear), .door_closed(door_closed), .timer_zero(timer_zero),
    .timer_loadn(timer_loadn), .timer_clrn(timer_clrn), .timer_enable(timer_enable),
    .mag_on(mag_on), .done_beep(done_beep), .state(state)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: outputs packed as {state, loadn, clrn, enable, mag_on, done_beep}
  always @(negedge clock) begin
    logic [7:0] act;
    exp_t e;
    act = {state, timer_loadn, timer_clrn, timer_enable, mag_on, done_beep};
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_cmp++;
      if (e.cyc != cyc) begin
        n_bad++;
        $display("FAIL %s: stale expectation for cycle %0d seen at cycle %0d", e.nm, e.cyc, cyc);
      end else if (act !== e.v) begin
        n_bad++;
        $display("FAIL %s: cycle %0d got st=%0d ln=%b cn=%b en=%b mag=%b beep=%b want st=%0d ln=%b cn=%b en=%b mag=%b beep=%b",
                 e.nm, cyc, act[7:5], act[4], act[3], act[2], act[1], act[0],
                 e.v[7:5], e.v[4], e.v[3], e.v[2], e.v[1], e.v[0]);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input logic [2:0] st, input logic ln, input logic cn, input logic en,
                     input logic mg, input logic bp, input string nm);
    exp_t e;
    e.cyc = cyc;
    e.v   = {st, ln, cn, en, mg, bp};
    e.nm  = nm;
    sb.push_back(e);
  endtask

  task automatic tick(input logic [2:0] st, input logic ln, input logic cn, input logic en,
                      input logic mg, input logic bp, input string nm);
    step();
    chk(st, ln, cn, en, mg, bp, nm);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    chk(3'd0, 1, 1, 0, 0, 0, "reset_hold");
    step();
    clrn = 1'b1;
    tick(3'd0, 1, 1, 0, 0, 0, "reset_idle");

    // keypad loads
    key_valid = 1; tick(3'd1, 0, 1, 0, 0, 0, "key1_load");
    key_valid = 0; tick(3'd1, 1, 1, 0, 0, 0, "key1_one_cycle");
    key_valid = 1; tick(3'd1, 0, 1, 0, 0, 0, "key2_load");
    key_valid = 0; tick(3'd1, 1, 1, 0, 0, 0, "key2_one_cycle");

    // start refused: door open, then timer already zero
    door_closed = 0; start = 1; tick(3'd1, 1, 1, 0, 0, 0, "set_door_open_start");
    start = 0; door_closed = 1; timer_zero = 1;
    start = 1; tick(3'd1, 1, 1, 0, 0, 0, "set_zero_start");
    start = 0; timer_zero = 0;

    // cook: ticks at cycles 4, 8, 12 after entry
    start = 1; tick(3'd2, 1, 1, 0, 1, 0, "cook_entry");
    start = 0;
    for (int i = 1; i <= 14; i++)
      tick(3'd2, 1, 1, (i % 4 == 0), 1, 0, $sformatf("cook_c%0d", i));

    // door opens two cycles after a tick
    door_closed = 0; tick(3'd3, 1, 1, 0, 0, 0, "pause_entry");
    for (int i = 0; i < 3; i++) tick(3'd3, 1, 1, 0, 0, 0, "pause_hold");
    door_closed = 1; tick(3'd3, 1, 1, 0, 0, 0, "pause_door_closed");
    start = 1; tick(3'd2, 1, 1, 0, 1, 0, "resume_entry");
    start = 0;
    tick(3'd2, 1, 1, 0, 1, 0, "resume_c1");
    tick(3'd2, 1, 1, 1, 1, 0, "resume_tick");
    tick(3'd2, 1, 1, 0, 1, 0, "resume_c3");

    // timer reaches zero: beep three cycles
    timer_zero = 1; tick(3'd4, 1, 1, 0, 0, 1, "done_entry");
    timer_zero = 0;
    tick(3'd4, 1, 1, 0, 0, 1, "done_c2");
    tick(3'd4, 1, 1, 0, 0, 1, "done_c3");
    tick(3'd0, 1, 1, 0, 0, 0, "done_to_idle");

    // done ended early by stop_clear
    key_valid = 1; tick(3'd1, 0, 1, 0, 0, 0, "key3_load");
    key_valid = 0; tick(3'd1, 1, 1, 0, 0, 0, "key3_release");
    start = 1; tick(3'd2, 1, 1, 0, 1, 0, "cook2_entry");
    start = 0;
    timer_zero = 1; tick(3'd4, 1, 1, 0, 0, 1, "done2_entry");
    timer_zero = 0; tick(3'd4, 1, 1, 0, 0, 1, "done2_c2");
    stop_clear = 1; tick(3'd0, 1, 1, 0, 0, 0, "done2_stop");
    stop_clear = 0;

    // clear from SET
    key_valid = 1; tick(3'd1, 0, 1, 0, 0, 0, "key4_load");
    key_valid = 0;
    stop_clear = 1; tick(3'd0, 1, 0, 0, 0, 0, "set_clear");
    stop_clear = 0; tick(3'd0, 1, 1, 0, 0, 0, "set_clear_one_cycle");

    // pause by stop_clear, then clear from PAUSE
    key_valid = 1; tick(3'd1, 0, 1, 0, 0, 0, "key5_load");
    key_valid = 0;
    start = 1; tick(3'd2, 1, 1, 0, 1, 0, "cook3_entry");
    start = 0;
    stop_clear = 1; tick(3'd3, 1, 1, 0, 0, 0, "cook_stop_pause");
    stop_clear = 0; tick(3'd3, 1, 1, 0, 0, 0, "pause_wait");
    stop_clear = 1; tick(3'd0, 1, 0, 0, 0, 0, "pause_clear");
    stop_clear = 0; tick(3'd0, 1, 1, 0, 0, 0, "pause_clear_one_cycle");

    // cleared prescaler: fresh cook ticks 4 cycles after entry
    key_valid = 1; tick(3'd1, 0, 1, 0, 0, 0, "key6_load");
    key_valid = 0;
    start = 1; tick(3'd2, 1, 1, 0, 1, 0, "cook4_entry");
    start = 0;
    tick(3'd2, 1, 1, 0, 1, 0, "cook4_c1");
    tick(3'd2, 1, 1, 0, 1, 0, "cook4_c2");

    // asynchronous reset mid-cook
    step();
    clrn = 0;
    #1;
    chk(3'd0, 1, 1, 0, 0, 0, "async_reset");
    tick(3'd0, 1, 1, 0, 0, 0, "reset_held");
    clrn = 1;
    tick(3'd0, 1, 1, 0, 0, 0, "after_reset_idle");

    @(negedge clock);
    #1;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
